// File: rtl/cache_config_pkg.sv
// Shared types and constants for the LLC transaction scheduler.
// Opcodes, bus encodings, MESI states and scheduler FSM states.
package cache_config_pkg;

    localparam int LINE_OFFSET_BITS = 6;

    typedef enum logic [3:0] {
        TR_DREAD     = 4'd0,
        TR_WRITE     = 4'd1,
        TR_IREAD     = 4'd2,
        TR_SNP_READ  = 4'd3,
        TR_SNP_WRITE = 4'd4,
        TR_SNP_RWIM  = 4'd5,
        TR_SNP_INV   = 4'd6
    } trace_op_t;

    typedef enum logic [1:0] {
        BUS_READ       = 2'd0,
        BUS_WRITE      = 2'd1,
        BUS_RWIM       = 2'd2,
        BUS_INVALIDATE = 2'd3
    } bus_op_t;

    typedef enum logic [1:0] {
        SR_HIT   = 2'd0,
        SR_HITM  = 2'd1,
        SR_NOHIT = 2'd2
    } snoop_result_t;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CORE      = 3'd1,
        ST_WB_REQ    = 3'd2,
        ST_WB_WAIT   = 3'd3,
        ST_FILL_REQ  = 3'd4,
        ST_FILL_WAIT = 3'd5,
        ST_RESP      = 3'd6
    } sched_state_t;

    // Writes always own the line; reads share unless nobody else has it.
    function automatic mesi_t fill_state(input logic is_write,
                                         input logic [1:0] sr);
        if (is_write)
            return MESI_M;
        if (sr == SR_NOHIT)
            return MESI_E;
        return MESI_S;
    endfunction

endpackage

// File: rtl/llc_txn_scheduler_if.sv
// Processor, snoop, core and bus signal bundle of the scheduler.
// master = scheduler side, slave = environment side.
interface llc_txn_scheduler_if #(
    parameter int ADDR_W = 32
);
    logic              cpu_valid;
    logic              cpu_ready;
    logic [1:0]        cpu_op;
    logic [ADDR_W-1:0] cpu_addr;
    logic              snp_valid;
    logic [1:0]        snp_op;
    logic [ADDR_W-1:0] snp_addr;
    logic              core_valid;
    logic [3:0]        core_op;
    logic [ADDR_W-1:0] core_addr;
    logic              core_done;
    logic              core_hit;
    logic              core_victim_dirty;
    logic [ADDR_W-1:0] core_victim_addr;
    logic              fill_valid;
    logic [1:0]        fill_mesi;
    logic              bus_req;
    logic              bus_gnt;
    logic [1:0]        bus_op;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_done;
    logic [1:0]        snoop_result;
    logic              busy;
    logic              snp_overflow;

    modport master (
        input  cpu_valid, cpu_op, cpu_addr,
        input  snp_valid, snp_op, snp_addr,
        input  core_done, core_hit, core_victim_dirty, core_victim_addr,
        input  bus_gnt, bus_done, snoop_result,
        output cpu_ready, core_valid, core_op, core_addr,
        output fill_valid, fill_mesi,
        output bus_req, bus_op, bus_addr,
        output busy, snp_overflow
    );

    modport slave (
        output cpu_valid, cpu_op, cpu_addr,
        output snp_valid, snp_op, snp_addr,
        output core_done, core_hit, core_victim_dirty, core_victim_addr,
        output bus_gnt, bus_done, snoop_result,
        input  cpu_ready, core_valid, core_op, core_addr,
        input  fill_valid, fill_mesi,
        input  bus_req, bus_op, bus_addr,
        input  busy, snp_overflow
    );

endinterface

// File: rtl/llc_txn_scheduler_fifo.sv
// Small synchronous FIFO with full/empty flags.
// Push when full and pop when empty are ignored.
module txn_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push}
                           - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset; empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/llc_txn_scheduler.sv
// LLC transaction scheduler: snoop/processor arbitration,
// core command issue, victim writeback and line fill on the bus.
module llc_txn_scheduler
    import cache_config_pkg::*;
#(
    parameter int CPU_DEPTH = 4,
    parameter int SNP_DEPTH = 2,
    parameter int ADDR_W    = 32
) (
    input logic clk,
    input logic rst,
    llc_txn_scheduler_if.master sif
);
    localparam int EW = ADDR_W + 2;
    localparam int LO = LINE_OFFSET_BITS;

    sched_state_t      state, state_n;
    logic              cpu_push, cpu_pop, cpu_full, cpu_empty;
    logic              snp_push, snp_pop, snp_full, snp_empty;
    logic [EW-1:0]     cpu_head, snp_head;
    logic              cur_snp;
    logic [1:0]        cur_op;
    logic [ADDR_W-1:0] cur_addr, vic_addr;
    logic [ADDR_W-1:0] fill_addr, wb_addr;
    bus_op_t           fill_op;
    mesi_t             fill_q;
    logic              ovf_q;

    assign cpu_push = sif.cpu_valid && !cpu_full && (sif.cpu_op != 2'd3);
    assign snp_push = sif.snp_valid && !snp_full;

    assign sif.cpu_ready    = !cpu_full && !rst;
    assign sif.busy         = (state != ST_IDLE);
    assign sif.snp_overflow = ovf_q;

    assign fill_addr = {cur_addr[ADDR_W-1:LO], {LO{1'b0}}};
    assign wb_addr   = {vic_addr[ADDR_W-1:LO], {LO{1'b0}}};
    assign fill_op   = (cur_op == 2'd1) ? BUS_RWIM : BUS_READ;

    txn_fifo #(.W(EW), .DEPTH(CPU_DEPTH)) u_cpu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cpu_push),
        .pop   (cpu_pop),
        .din   ({sif.cpu_op, sif.cpu_addr}),
        .dout  (cpu_head),
        .full  (cpu_full),
        .empty (cpu_empty)
    );

    txn_fifo #(.W(EW), .DEPTH(SNP_DEPTH)) u_snp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (snp_push),
        .pop   (snp_pop),
        .din   ({sif.snp_op, sif.snp_addr}),
        .dout  (snp_head),
        .full  (snp_full),
        .empty (snp_empty)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // Capture the dispatched command, the dirty victim and the fill state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_snp  <= 1'b0;
            cur_op   <= 2'd0;
            cur_addr <= '0;
            vic_addr <= '0;
            fill_q   <= MESI_I;
        end else begin
            if (snp_pop || cpu_pop) begin
                cur_snp  <= snp_pop;
                cur_op   <= snp_pop ? snp_head[EW-1 -: 2] : cpu_head[EW-1 -: 2];
                cur_addr <= snp_pop ? snp_head[ADDR_W-1:0]
                                    : cpu_head[ADDR_W-1:0];
            end
            if (state == ST_CORE && sif.core_done && sif.core_victim_dirty)
                vic_addr <= sif.core_victim_addr;
            if (state == ST_FILL_WAIT && sif.bus_done)
                fill_q <= fill_state(cur_op == 2'd1, sif.snoop_result);
        end
    end

    // Sticky flag for a snoop that found its FIFO full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (sif.snp_valid && snp_full)
            ovf_q <= 1'b1;
    end

    // Next state, FIFO pops and all command/bus/fill outputs.
    always_comb begin
        state_n        = state;
        snp_pop        = 1'b0;
        cpu_pop        = 1'b0;
        sif.core_valid = 1'b0;
        sif.core_op    = 4'd0;
        sif.core_addr  = '0;
        sif.bus_req    = 1'b0;
        sif.bus_op     = BUS_READ;
        sif.bus_addr   = '0;
        sif.fill_valid = 1'b0;
        sif.fill_mesi  = MESI_I;
        unique case (state)
            ST_IDLE: begin
                if (!snp_empty) begin
                    snp_pop        = 1'b1;
                    sif.core_valid = 1'b1;
                    sif.core_op    = 4'(snp_head[EW-1 -: 2]) + 4'd3;
                    sif.core_addr  = snp_head[ADDR_W-1:0];
                    state_n        = ST_CORE;
                end else if (!cpu_empty) begin
                    cpu_pop        = 1'b1;
                    sif.core_valid = 1'b1;
                    sif.core_op    = 4'(cpu_head[EW-1 -: 2]);
                    sif.core_addr  = cpu_head[ADDR_W-1:0];
                    state_n        = ST_CORE;
                end
            end
            ST_CORE: begin
                if (sif.core_done) begin
                    if (cur_snp || sif.core_hit)
                        state_n = ST_IDLE;
                    else if (sif.core_victim_dirty)
                        state_n = ST_WB_REQ;
                    else
                        state_n = ST_FILL_REQ;
                end
            end
            ST_WB_REQ: begin
                sif.bus_req  = 1'b1;
                sif.bus_op   = BUS_WRITE;
                sif.bus_addr = wb_addr;
                if (sif.bus_gnt)
                    state_n = ST_WB_WAIT;
            end
            ST_WB_WAIT: begin
                sif.bus_op   = BUS_WRITE;
                sif.bus_addr = wb_addr;
                if (sif.bus_done)
                    state_n = ST_FILL_REQ;
            end
            ST_FILL_REQ: begin
                sif.bus_req  = 1'b1;
                sif.bus_op   = fill_op;
                sif.bus_addr = fill_addr;
                if (sif.bus_gnt)
                    state_n = ST_FILL_WAIT;
            end
            ST_FILL_WAIT: begin
                sif.bus_op   = fill_op;
                sif.bus_addr = fill_addr;
                if (sif.bus_done)
                    state_n = ST_RESP;
            end
            ST_RESP: begin
                sif.fill_valid = 1'b1;
                sif.fill_mesi  = fill_q;
                state_n        = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_llc_txn_scheduler.sv
// Self-checking bench for llc_txn_scheduler.
// Directed scenarios plus randomized traffic against a queue model.
module tb_llc_txn_scheduler;
    import cache_config_pkg::*;

    localparam int AW    = 32;
    localparam int CPU_D = 4;
    localparam int SNP_D = 2;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   exp_ovf = 1'b0;
    ent_t cpu_q[$];
    ent_t snp_q[$];

    always #5 clk = ~clk;

    llc_txn_scheduler_if #(.ADDR_W(AW)) sif ();

    llc_txn_scheduler #(
        .CPU_DEPTH (CPU_D),
        .SNP_DEPTH (SNP_D),
        .ADDR_W    (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sif.cpu_valid         = 1'b0;
        sif.cpu_op            = 2'd0;
        sif.cpu_addr          = '0;
        sif.snp_valid         = 1'b0;
        sif.snp_op            = 2'd0;
        sif.snp_addr          = '0;
        sif.core_done         = 1'b0;
        sif.core_hit          = 1'b0;
        sif.core_victim_dirty = 1'b0;
        sif.core_victim_addr  = '0;
        sif.bus_gnt           = 1'b0;
        sif.bus_done          = 1'b0;
        sif.snoop_result      = 2'd0;
    endtask

    function automatic logic [1:0] exp_fill(input logic [1:0] op,
                                            input logic [1:0] sr);
        if (op == 2'd1)
            return MESI_M;
        if (sr == 2'd2)
            return MESI_E;
        return MESI_S;
    endfunction

    task automatic snoop_push(input logic [1:0] op, input logic [31:0] a);
        sif.snp_valid = 1'b1;
        sif.snp_op    = op;
        sif.snp_addr  = a;
        if (snp_q.size() < SNP_D)
            snp_q.push_back('{op, a});
        else
            exp_ovf = 1'b1;
        step();
        sif.snp_valid = 1'b0;
    endtask

    task automatic cpu_push(input logic [1:0] op, input logic [31:0] a,
                            input bit do_snp, input logic [1:0] sop,
                            input logic [31:0] sa);
        sif.cpu_valid = 1'b1;
        sif.cpu_op    = op;
        sif.cpu_addr  = a;
        if (op != 2'd3 && cpu_q.size() < CPU_D)
            cpu_q.push_back('{op, a});
        if (do_snp) begin
            sif.snp_valid = 1'b1;
            sif.snp_op    = sop;
            sif.snp_addr  = sa;
            if (snp_q.size() < SNP_D)
                snp_q.push_back('{sop, sa});
            else
                exp_ovf = 1'b1;
        end
        step();
        sif.cpu_valid = 1'b0;
        sif.snp_valid = 1'b0;
    endtask

    task automatic wait_dispatch(input logic [3:0] op, input logic [31:0] a,
                                 input string tag);
        int n = 0;
        @(negedge clk);
        while (!sif.core_valid && n < 30) begin
            step();
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, sif.core_valid, 1);
        chk({tag, "_op"}, sif.core_op, op);
        chk({tag, "_addr"}, sif.core_addr, a);
        step();
    endtask

    task automatic core_resp(input bit hit, input bit dirty,
                             input logic [31:0] va, input int delay,
                             input int ns, input bit back_idle);
        for (int i = 0; i < delay; i++) begin
            if (i < ns)
                snoop_push(2'($urandom), $urandom);
            else
                step();
        end
        sif.core_done         = 1'b1;
        sif.core_hit          = hit;
        sif.core_victim_dirty = dirty;
        sif.core_victim_addr  = va;
        chk("core_busy", sif.busy, 1);
        chk("core_noreq", sif.bus_req, 0);
        step();
        sif.core_done         = 1'b0;
        sif.core_hit          = 1'b0;
        sif.core_victim_dirty = 1'b0;
        if (back_idle)
            chk("core_idle_after", sif.busy, 0);
    endtask

    task automatic bus_txn(input logic [1:0] op, input logic [31:0] a,
                           input logic [1:0] sr, input int gd, input int dd,
                           input int ns, input string tag);
        int n = 0;
        @(negedge clk);
        while (!sif.bus_req && n < 30) begin
            step();
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, sif.bus_req, 1);
        chk({tag, "_op"}, sif.bus_op, op);
        chk({tag, "_addr"}, sif.bus_addr, a);
        for (int i = 0; i < gd; i++) begin
            step();
            chk({tag, "_hold"}, {sif.bus_req, sif.bus_op, sif.bus_addr},
                {1'b1, op, a});
        end
        sif.bus_gnt = 1'b1;
        step();
        sif.bus_gnt = 1'b0;
        chk({tag, "_req_drop"}, sif.bus_req, 0);
        for (int i = 0; i < dd; i++) begin
            if (i < ns)
                snoop_push(2'($urandom), $urandom);
            else
                step();
        end
        sif.bus_done     = 1'b1;
        sif.snoop_result = sr;
        step();
        sif.bus_done     = 1'b0;
    endtask

    task automatic expect_fill(input logic [1:0] m, input string tag);
        chk({tag, "_fv"}, sif.fill_valid, 1);
        chk({tag, "_mesi"}, sif.fill_mesi, m);
        step();
        chk({tag, "_fv_end"}, sif.fill_valid, 0);
        chk({tag, "_idle"}, sif.busy, 0);
    endtask

    task automatic expect_quiet(input int n, input string tag);
        int cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (sif.core_valid || sif.fill_valid || sif.bus_req)
                cnt++;
            step();
        end
        chk(tag, cnt, 0);
    endtask

    task automatic serve_all();
        ent_t        e;
        int          guard = 0;
        int          ns;
        bit          hit;
        bit          dirty;
        logic [31:0] va;
        logic [1:0]  sr;
        while ((snp_q.size() + cpu_q.size()) > 0 && guard < 64) begin
            guard++;
            if (snp_q.size() > 0) begin
                e = snp_q.pop_front();
                wait_dispatch(4'(e.op) + 4'd3, e.addr, "snp_cmd");
                core_resp(1'($urandom), 1'($urandom), $urandom,
                          $urandom_range(0, 2), 0, 1'b1);
            end else begin
                e = cpu_q.pop_front();
                wait_dispatch(4'(e.op), e.addr, "cpu_cmd");
                hit   = 1'($urandom);
                dirty = 1'($urandom);
                va    = $urandom & 32'hFFFF_FFC0;
                ns    = $urandom_range(0, 3);
                core_resp(hit, dirty, va, ns + $urandom_range(0, 1), ns, hit);
                if (!hit) begin
                    if (dirty) begin
                        ns = $urandom_range(0, 2);
                        bus_txn(BUS_WRITE, va, 2'($urandom),
                                $urandom_range(0, 2), ns + 1, ns, "wb");
                    end
                    sr = 2'($urandom);
                    ns = $urandom_range(0, 2);
                    bus_txn((e.op == 2'd1) ? BUS_RWIM : BUS_READ,
                            e.addr & 32'hFFFF_FFC0, sr,
                            $urandom_range(0, 2), ns, ns, "fill");
                    expect_fill(exp_fill(e.op, sr), "fill");
                end
            end
        end
    endtask

    initial begin
        ent_t e;
        idle_inputs();
        rst = 1'b1;
        #3;
        chk("rst_core_valid", sif.core_valid, 0);
        chk("rst_busy", sif.busy, 0);
        chk("rst_bus_req", sif.bus_req, 0);
        chk("rst_fill_valid", sif.fill_valid, 0);
        chk("rst_cpu_ready", sif.cpu_ready, 0);
        chk("rst_ovf", sif.snp_overflow, 0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rel_cpu_ready", sif.cpu_ready, 1);

        // Hit at 0x1040.
        cpu_push(2'd0, 32'h0000_1040, 1'b0, 2'd0, '0);
        e = cpu_q.pop_front();
        wait_dispatch(4'd0, 32'h0000_1040, "hit");
        core_resp(1'b1, 1'b0, '0, 0, 0, 1'b1);
        expect_quiet(3, "hit_quiet");

        // Clean read miss, NOHIT then HITM.
        cpu_push(2'd0, 32'h1234_5678, 1'b0, 2'd0, '0);
        e = cpu_q.pop_front();
        wait_dispatch(4'd0, 32'h1234_5678, "rdm");
        core_resp(1'b0, 1'b0, '0, 1, 0, 1'b0);
        bus_txn(BUS_READ, 32'h1234_5640, SR_NOHIT, 1, 1, 0, "rdm");
        expect_fill(MESI_E, "rdm_e");
        cpu_push(2'd0, 32'h1234_5678, 1'b0, 2'd0, '0);
        e = cpu_q.pop_front();
        wait_dispatch(4'd0, 32'h1234_5678, "rdm2");
        core_resp(1'b0, 1'b0, '0, 0, 0, 1'b0);
        bus_txn(BUS_READ, 32'h1234_5640, SR_HITM, 0, 0, 0, "rdm2");
        expect_fill(MESI_S, "rdm2_s");

        // Dirty write miss.
        cpu_push(2'd1, 32'hABCD_0000, 1'b0, 2'd0, '0);
        e = cpu_q.pop_front();
        wait_dispatch(4'd1, 32'hABCD_0000, "wrm");
        core_resp(1'b0, 1'b1, 32'h5550_0000, 0, 0, 1'b0);
        bus_txn(BUS_WRITE, 32'h5550_0000, SR_HIT, 2, 0, 0, "wrm_wb");
        bus_txn(BUS_RWIM, 32'hABCD_0000, SR_HIT, 0, 2, 0, "wrm_rwim");
        expect_fill(MESI_M, "wrm_m");

        // Snoop beats a same-cycle processor request.
        cpu_push(2'd2, 32'h0000_2000, 1'b1, 2'd2, 32'h0000_3000);
        e = snp_q.pop_front();
        e = cpu_q.pop_front();
        wait_dispatch(4'd5, 32'h0000_3000, "prio_snp");
        core_resp(1'b0, 1'b1, '0, 0, 0, 1'b1);
        wait_dispatch(4'd2, 32'h0000_2000, "prio_cpu");
        core_resp(1'b1, 1'b0, '0, 0, 0, 1'b1);

        // Three snoops during FILL_WAIT into a two-entry FIFO.
        cpu_push(2'd0, 32'h0000_8000, 1'b0, 2'd0, '0);
        e = cpu_q.pop_front();
        wait_dispatch(4'd0, 32'h0000_8000, "ovf");
        core_resp(1'b0, 1'b0, '0, 0, 0, 1'b0);
        bus_txn(BUS_READ, 32'h0000_8000, SR_HIT, 0, 4, 3, "ovf");
        expect_fill(MESI_S, "ovf");
        chk("ovf_flag", sif.snp_overflow, exp_ovf);
        chk("ovf_model_snps", snp_q.size(), 2);
        serve_all();
        expect_quiet(6, "ovf_quiet");
        chk("ovf_sticky", sif.snp_overflow, 1);

        // Reserved op dropped; processor FIFO full boundary.
        cpu_push(2'd3, 32'h0000_9999, 1'b0, 2'd0, '0);
        expect_quiet(4, "rsv_quiet");
        cpu_push(2'd0, 32'h0000_A000, 1'b0, 2'd0, '0);
        e = cpu_q.pop_front();
        wait_dispatch(4'd0, 32'h0000_A000, "full_first");
        for (int i = 0; i < 4; i++)
            cpu_push(2'(i % 3), 32'h0000_B000 + 32'(i * 64), 1'b0, 2'd0, '0);
        chk("full_ready", sif.cpu_ready, 0);
        cpu_push(2'd1, 32'h0000_C000, 1'b0, 2'd0, '0);
        chk("full_model", cpu_q.size(), 4);
        core_resp(1'b1, 1'b0, '0, 0, 0, 1'b1);
        serve_all();
        expect_quiet(5, "full_quiet");

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            cpu_push(2'($urandom_range(0, 2)), $urandom, 1'($urandom),
                     2'($urandom), $urandom);
            serve_all();
            chk("rnd_ovf", sif.snp_overflow, exp_ovf);
            chk("rnd_busy", sif.busy, 0);
        end

        // Reset in FILL_WAIT with queued work.
        cpu_push(2'd0, 32'h0000_4000, 1'b0, 2'd0, '0);
        e = cpu_q.pop_front();
        wait_dispatch(4'd0, 32'h0000_4000, "rmo");
        core_resp(1'b0, 1'b0, '0, 0, 0, 1'b0);
        @(negedge clk);
        chk("rmo_req", sif.bus_req, 1);
        sif.bus_gnt = 1'b1;
        step();
        sif.bus_gnt = 1'b0;
        cpu_push(2'd2, 32'h0000_5000, 1'b1, 2'd0, 32'h0000_6000);
        #2;
        rst = 1'b1;
        #1;
        chk("rmo_busy", sif.busy, 0);
        chk("rmo_bus_req", sif.bus_req, 0);
        chk("rmo_fill", sif.fill_valid, 0);
        chk("rmo_core_valid", sif.core_valid, 0);
        chk("rmo_ready", sif.cpu_ready, 0);
        chk("rmo_ovf", sif.snp_overflow, 0);
        sif.bus_done     = 1'b1;
        sif.snoop_result = 2'd2;
        step();
        sif.bus_done = 1'b0;
        rst          = 1'b0;
        cpu_q.delete();
        snp_q.delete();
        exp_ovf = 1'b0;
        #1;
        chk("rmo_rel_ready", sif.cpu_ready, 1);
        chk("rmo_rel_busy", sif.busy, 0);
        sif.bus_done = 1'b1;
        step();
        sif.bus_done = 1'b0;
        expect_quiet(6, "rmo_quiet");

        // Life after reset.
        cpu_push(2'd0, 32'h0000_7000, 1'b0, 2'd0, '0);
        serve_all();
        chk("end_ovf", sif.snp_overflow, exp_ovf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
